// File: rtl/imem_arbiter_pkg.sv
// rtl/imem_arbiter_pkg.sv - shared types for the instruction-memory arbiter
//
// Package riscv_structures: response-tracking state enum and the
// request/response structs. Structs are sized to the widest supported
// address/data width; users zero-extend into them and truncate out.
package riscv_structures;

    localparam int IMEM_AW_MAX = 64;
    localparam int IMEM_DW_MAX = 64;

    // Which requester owns the memory read data in the current cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RSP_FE = 2'd1,
        RSP_LD = 2'd2
    } imem_rsp_state_e;

    typedef struct packed {
        logic                   we;
        logic [IMEM_AW_MAX-1:0] addr;
        logic [IMEM_DW_MAX-1:0] wdata;
    } imem_req_t;

    typedef struct packed {
        logic                   valid;
        logic [IMEM_DW_MAX-1:0] data;
    } imem_rsp_t;

endpackage

// File: rtl/imem_arbiter_if.sv
// rtl/imem_arbiter_if.sv - fetch/loader/memory bundle for the arbiter
//
// slave  : arbiter view (requests and mem_rdata in; readies, responses and
//          memory command out)
// master : requester/memory-model view (the mirror image)
interface imem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              fe_req_valid;
    logic              fe_req_ready;
    logic [ADDR_W-1:0] fe_req_addr;
    logic              fe_rsp_valid;
    logic [DATA_W-1:0] fe_rsp_data;
    logic              fe_flush;

    logic              ld_req_valid;
    logic              ld_req_ready;
    logic              ld_req_we;
    logic [ADDR_W-1:0] ld_req_addr;
    logic [DATA_W-1:0] ld_req_wdata;
    logic              ld_rsp_valid;
    logic [DATA_W-1:0] ld_rsp_data;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  fe_req_valid, fe_req_addr, fe_flush,
        input  ld_req_valid, ld_req_we, ld_req_addr, ld_req_wdata,
        input  mem_rdata,
        output fe_req_ready, fe_rsp_valid, fe_rsp_data,
        output ld_req_ready, ld_rsp_valid, ld_rsp_data,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output fe_req_valid, fe_req_addr, fe_flush,
        output ld_req_valid, ld_req_we, ld_req_addr, ld_req_wdata,
        output mem_rdata,
        input  fe_req_ready, fe_rsp_valid, fe_rsp_data,
        input  ld_req_ready, ld_rsp_valid, ld_rsp_data,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_arbiter_pick.sv
// rtl/imem_arbiter_pick.sv - fetch/loader grant decision and burst counter
//
// Module imem_arb_pick. Optional macro: IMEM_ARB_LOCK_EN (adds ld_lock).
// Ports:
//   clk, reset_n          clock, async active-low reset
//   fe_valid, ld_valid    request valids
//   ld_lock               loader strict priority (IMEM_ARB_LOCK_EN only)
//   fe_ready, ld_ready    combinational readies (0 while in reset)
//   fe_grant, ld_grant    one-hot-or-zero grant of this cycle
module imem_arb_pick #(
    parameter int MAX_FE_BURST = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic fe_valid,
    input  logic ld_valid,
`ifdef IMEM_ARB_LOCK_EN
    input  logic ld_lock,
`endif
    output logic fe_ready,
    output logic ld_ready,
    output logic fe_grant,
    output logic ld_grant
);
    localparam int CNT_W = $clog2(MAX_FE_BURST + 1);

    logic [CNT_W-1:0] fe_burst_cnt_q, fe_burst_cnt_d;
    logic             ld_turn;

    always_comb begin
        ld_turn        = ld_valid && (fe_burst_cnt_q == CNT_W'(MAX_FE_BURST));
        fe_ready       = 1'b0;
        ld_ready       = 1'b0;
        fe_grant       = 1'b0;
        ld_grant       = 1'b0;
        fe_burst_cnt_d = fe_burst_cnt_q;

        if (reset_n) begin
`ifdef IMEM_ARB_LOCK_EN
            fe_ready = !ld_turn && !ld_lock;
            ld_ready = ld_lock || !fe_valid || ld_turn;
`else
            fe_ready = !ld_turn;
            ld_ready = !fe_valid || ld_turn;
`endif
        end
        fe_grant = fe_valid && fe_ready;
        ld_grant = ld_valid && ld_ready;

        // Count fetch wins only while the loader is actually waiting.
        if (!ld_valid || ld_grant) begin
            fe_burst_cnt_d = '0;
        end else if (fe_grant && (fe_burst_cnt_q != CNT_W'(MAX_FE_BURST))) begin
            fe_burst_cnt_d = fe_burst_cnt_q + 1'b1;
        end
`ifdef IMEM_ARB_LOCK_EN
        // Held at zero while locked, so release always starts a fresh burst.
        if (ld_lock) begin
            fe_burst_cnt_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fe_burst_cnt_q <= '0;
        end else begin
            fe_burst_cnt_q <= fe_burst_cnt_d;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - single-port instruction memory arbiter (fetch vs loader)
//
// Optional macro: IMEM_ARB_LOCK_EN (adds ld_lock input, loader strict priority).
// Ports:
//   clk, reset_n   clock, async active-low reset
//   ld_lock        loader lock (IMEM_ARB_LOCK_EN only)
//   bus (slave)    fetch req/rsp + fe_flush, loader req/rsp, memory port
// Memory has one-cycle read latency, so the response is produced the cycle
// after the grant; the FSM remembers whose data mem_rdata carries.
module imem_arbiter
    import riscv_structures::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_FE_BURST = 4
) (
    input  logic           clk,
    input  logic           reset_n,
`ifdef IMEM_ARB_LOCK_EN
    input  logic           ld_lock,
`endif
    imem_arbiter_if.slave  bus
);
    logic fe_grant, ld_grant, fe_ready, ld_ready;

    imem_arb_pick #(
        .MAX_FE_BURST(MAX_FE_BURST)
    ) u_pick (
        .clk      (clk),
        .reset_n  (reset_n),
        .fe_valid (bus.fe_req_valid),
        .ld_valid (bus.ld_req_valid),
`ifdef IMEM_ARB_LOCK_EN
        .ld_lock  (ld_lock),
`endif
        .fe_ready (fe_ready),
        .ld_ready (ld_ready),
        .fe_grant (fe_grant),
        .ld_grant (ld_grant)
    );

    imem_rsp_state_e state_q, state_d;
    logic            ld_wr_q, ld_wr_d;
    logic            flush_pend_q, flush_pend_d;
    logic            fe_live_due;
    imem_req_t       fe_req, ld_req, sel_req;
    imem_rsp_t       fe_rsp, ld_rsp;
    logic [IMEM_DW_MAX-1:0] rdata_ext;
    logic            unused_pad;

    always_comb begin
        fe_req       = '0;
        fe_req.addr  = IMEM_AW_MAX'(bus.fe_req_addr);
        ld_req       = '0;
        ld_req.we    = bus.ld_req_we;
        ld_req.addr  = IMEM_AW_MAX'(bus.ld_req_addr);
        ld_req.wdata = IMEM_DW_MAX'(bus.ld_req_wdata);
        sel_req      = ld_grant ? ld_req : fe_req;
        rdata_ext    = IMEM_DW_MAX'(bus.mem_rdata);

        state_d = IDLE;
        if (fe_grant) begin
            state_d = RSP_FE;
        end else if (ld_grant) begin
            state_d = RSP_LD;
        end
        ld_wr_d = ld_grant && bus.ld_req_we;

        // A flush kills the oldest live fetch: the response due now if there
        // is one, otherwise the fetch being granted in the same cycle. This
        // lets a redirect fetch issued alongside the flush survive.
        fe_live_due  = (state_q == RSP_FE) && !flush_pend_q;
        flush_pend_d = fe_grant && bus.fe_flush && !fe_live_due;

        fe_rsp       = '0;
        fe_rsp.valid = fe_live_due && !bus.fe_flush;
        if (fe_rsp.valid) begin
            fe_rsp.data = rdata_ext;
        end

        ld_rsp       = '0;
        ld_rsp.valid = (state_q == RSP_LD);
        if (ld_rsp.valid && !ld_wr_q) begin
            ld_rsp.data = rdata_ext;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            ld_wr_q      <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ld_wr_q      <= ld_wr_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // Grants are already forced low in reset, so the memory command and
    // responses fall to zero without extra gating.
    assign bus.fe_req_ready = fe_ready;
    assign bus.ld_req_ready = ld_ready;
    assign bus.mem_en       = fe_grant || ld_grant;
    assign bus.mem_we       = ld_grant && sel_req.we;
    assign bus.mem_addr     = bus.mem_en ? ADDR_W'(sel_req.addr) : '0;
    assign bus.mem_wdata    = bus.mem_we ? DATA_W'(sel_req.wdata) : '0;
    assign bus.fe_rsp_valid = fe_rsp.valid;
    assign bus.fe_rsp_data  = DATA_W'(fe_rsp.data);
    assign bus.ld_rsp_valid = ld_rsp.valid;
    assign bus.ld_rsp_data  = DATA_W'(ld_rsp.data);

    // Upper padding bits of the max-width structs are never consumed.
    assign unused_pad = ^{sel_req, fe_rsp, ld_rsp};

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - scoreboard bench for imem_arbiter
module tb_imem_arbiter;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    imem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef IMEM_ARB_LOCK_EN
    logic ld_lock_r = 1'b0;
    logic lock_nxt  = 1'b0;
`endif

    imem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_FE_BURST(4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
`ifdef IMEM_ARB_LOCK_EN
        .ld_lock (ld_lock_r),
`endif
        .bus     (bus)
    );

    // Memory model: word i preloaded with 0xA0000000 | (i*4).
    logic [31:0] mem [0:63];
    initial for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 | (i << 2);
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
            else            bus.mem_rdata <= mem[bus.mem_addr[7:2]];
        end
    end

    typedef struct { int kind; logic [31:0] addr; logic we; } gnt_t;
    typedef struct { logic [31:0] data; int cyc; } rsp_t;
    gnt_t gnt_q[$];
    rsp_t fe_q[$];
    rsp_t ld_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
    endtask

    // Monitor: pops an expectation whenever the DUT grants or responds.
    always @(negedge clk) begin
        gnt_t g;
        rsp_t r;
        if (bus.mem_en) begin
            if (gnt_q.size() == 0) flag("grant_extra");
            else begin
                g = gnt_q.pop_front();
                check("grant_kind", (bus.fe_req_valid && bus.fe_req_ready) ? 32'd1 : 32'd2, 32'(g.kind));
                check("grant_addr", bus.mem_addr, g.addr);
                check("grant_we", 32'(bus.mem_we), 32'(g.we));
            end
        end
        if (bus.fe_rsp_valid) begin
            if (fe_q.size() == 0) flag("fe_rsp_extra");
            else begin
                r = fe_q.pop_front();
                check("fe_rsp_data", bus.fe_rsp_data, r.data);
                check("fe_rsp_cycle", 32'(cyc), 32'(r.cyc));
            end
        end
        if (bus.ld_rsp_valid) begin
            if (ld_q.size() == 0) flag("ld_rsp_extra");
            else begin
                r = ld_q.pop_front();
                check("ld_rsp_data", bus.ld_rsp_data, r.data);
                check("ld_rsp_cycle", 32'(cyc), 32'(r.cyc));
            end
        end
    end

    // One cycle of stimulus; g: 0 none, 1 fetch, 2 loader expected to win.
    task automatic step(input bit fv, input logic [31:0] fa, input bit lv, input bit lwe,
                        input logic [31:0] la, input logic [31:0] lwd, input bit fl,
                        input int g, input bit rsp_on, input logic [31:0] rd);
        @(posedge clk);
        #1;
`ifdef IMEM_ARB_LOCK_EN
        ld_lock_r = lock_nxt;
`endif
        bus.fe_req_valid = fv;  bus.fe_req_addr  = fa;  bus.fe_flush = fl;
        bus.ld_req_valid = lv;  bus.ld_req_we    = lwe;
        bus.ld_req_addr  = la;  bus.ld_req_wdata = lwd;
        if (g == 1) gnt_q.push_back('{kind: 1, addr: fa, we: 1'b0});
        if (g == 2) gnt_q.push_back('{kind: 2, addr: la, we: lwe});
        if (rsp_on && g == 1) fe_q.push_back('{data: rd, cyc: cyc + 1});
        if (rsp_on && g == 2) ld_q.push_back('{data: rd, cyc: cyc + 1});
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_reset_outputs();
        check("rst_ctrl", 32'({bus.fe_req_ready, bus.ld_req_ready, bus.mem_en, bus.mem_we,
                               bus.fe_rsp_valid, bus.ld_rsp_valid}), 32'd0);
        check("rst_data", bus.mem_addr | bus.mem_wdata | bus.fe_rsp_data | bus.ld_rsp_data, 32'd0);
    endtask

    initial begin
        bus.fe_req_valid = 1'b1; bus.fe_req_addr  = 32'h0; bus.fe_flush = 1'b0;
        bus.ld_req_valid = 1'b1; bus.ld_req_we    = 1'b0;
        bus.ld_req_addr  = 32'h0; bus.ld_req_wdata = 32'h0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;

        // Reset state with both requesters asserting.
        repeat (2) begin @(negedge clk); chk_reset_outputs(); end
        bus.fe_req_valid = 1'b0; bus.ld_req_valid = 1'b0;
        #4 reset_n = 1'b1;

        // Back-to-back fetches, granted in the first cycle after reset.
        step(1, 32'h0, 0, 0, 0, 0, 0, 1, 1, 32'hA000_0000);
        step(1, 32'h4, 0, 0, 0, 0, 0, 1, 1, 32'hA000_0004);
        step(1, 32'h8, 0, 0, 0, 0, 0, 1, 1, 32'hA000_0008);
        idle();

        // Loader write then fetch of the same word.
        step(0, 0, 1, 1, 32'h10, 32'hDEAD_BEEF, 0, 2, 1, 32'h0);
        step(1, 32'h10, 0, 0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF);
        idle();

        // Contention: FE x4 then LD, twice.
        repeat (2) begin
            repeat (4) step(1, 32'h20, 1, 0, 32'h24, 0, 0, 1, 1, 32'hA000_0020);
            step(1, 32'h20, 1, 0, 32'h24, 0, 0, 2, 1, 32'hA000_0024);
        end
        idle();

        // Flush of the in-flight fetch; redirect fetch with flush survives.
        step(1, 32'h0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 32'h4, 0, 0, 0, 0, 1, 1, 1, 32'hA000_0004);
        idle();
        // Flush in the grant cycle with nothing in flight kills that grant.
        step(1, 32'h8, 0, 0, 0, 0, 1, 1, 0, 0);
        step(1, 32'hC, 0, 0, 0, 0, 0, 1, 1, 32'hA000_000C);
        idle();
        // Flush never touches the loader.
        step(0, 0, 1, 0, 32'h28, 0, 1, 2, 1, 32'hA000_0028);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle();

        // Reset right after a loader read grant: response is dropped.
        step(0, 0, 1, 0, 32'h2C, 0, 0, 2, 0, 0);
        @(negedge clk);
        #2 reset_n = 1'b0;
        bus.fe_req_valid = 1'b1;
        repeat (3) begin @(negedge clk); chk_reset_outputs(); end
        bus.fe_req_valid = 1'b0; bus.ld_req_valid = 1'b0;
        #4 reset_n = 1'b1;
        step(1, 32'h4, 0, 0, 0, 0, 0, 1, 1, 32'hA000_0004);
        idle();

`ifdef IMEM_ARB_LOCK_EN
        lock_nxt = 1'b1;
        repeat (10) begin
            step(1, 32'h8, 0, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            check("lock_fe_ready", 32'(bus.fe_req_ready), 32'd0);
        end
        lock_nxt = 1'b0;
        step(1, 32'h8, 0, 0, 0, 0, 0, 1, 1, 32'hA000_0008);
        idle();
`endif

        idle();
        idle();
        check("gnt_left", 32'(gnt_q.size()), 32'd0);
        check("fe_left", 32'(fe_q.size()), 32'd0);
        check("ld_left", 32'(ld_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width in bits.
REQ-002 SHALL have parameter DATA_W, default 32, instruction/data word width.
REQ-003 SHALL have parameter MAX_FE_BURST, default 4, the maximum number of consecutive fetch grants while the loader waits.
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have ports fe_req_valid/fe_req_ready  in/out  1  fetch request handshake; fe_req_addr  in  ADDR_W.
REQ-007 SHALL have ports fe_rsp_valid  out  1, fe_rsp_data  out  DATA_W  fetch read response.
REQ-008 SHALL have port fe_flush  in  1  discards the in-flight fetch response on PC redirect.
REQ-009 SHALL have ports ld_req_valid/ld_req_ready  in/out  1; ld_req_we  in  1; ld_req_addr  in  ADDR_W; ld_req_wdata  in  DATA_W  loader/debug request.
REQ-010 SHALL have ports ld_rsp_valid  out  1, ld_rsp_data  out  DATA_W  loader response.
REQ-011 SHALL have ports mem_en, mem_we  out  1; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_rdata  in  DATA_W  single-port instruction memory, one-cycle synchronous read.
REQ-012 SHALL have port ld_lock  in  1, present only when IMEM_ARB_LOCK_EN is defined.

Function
REQ-013 A request SHALL be granted in cycle N when valid and ready are both high; at most one grant per cycle.
REQ-014 The grant SHALL drive mem_en=1, mem_addr, mem_we and mem_wdata combinationally in cycle N; mem_en=0 and mem_we=0 in cycles with no grant.
REQ-015 The response SHALL appear in cycle N+1 (latency 1): rsp_valid is a one-cycle pulse, and rsp_data=mem_rdata for reads and 0 for loader writes.
REQ-016 Back-to-back grants SHALL be supported, giving throughput of one request per cycle with no bubble.
REQ-017 Only fetch alone valid: fetch granted; only loader alone valid: loader granted.
REQ-018 Both valid: fetch SHALL win unless fe_burst_cnt==MAX_FE_BURST, in which case the loader wins.
REQ-019 fe_burst_cnt SHALL increment on each fetch grant while ld_req_valid=1 and saturate at MAX_FE_BURST; it SHALL clear on a loader grant or in any cycle with ld_req_valid=0.
REQ-020 ready outputs SHALL be combinational from the current valids and state; the losing requester sees ready=0 and must hold its request stable.
REQ-021 The tracking FSM SHALL have states IDLE (no response pending), RSP_FE and RSP_LD; next state is set by the grant of the current cycle (none -> IDLE).
REQ-022 fe_flush=1 in cycle N+1 SHALL force fe_rsp_valid=0 for the response due that cycle; fe_flush in the grant cycle N SHALL also suppress that grant's response.
REQ-023 fe_flush SHALL NOT affect loader requests or responses, nor block a new fetch grant in the same cycle.

Reset
REQ-024 reset_n=0 SHALL asynchronously set state=IDLE, fe_burst_cnt=0, fe_rsp_valid=0, ld_rsp_valid=0 and the flush-pending flag=0.
REQ-025 While reset_n=0, fe_req_ready, ld_req_ready, mem_en and mem_we SHALL be 0 and data outputs SHALL be 0.
REQ-026 Reset mid-operation SHALL drop any in-flight response silently; the first grant is possible in the first cycle after deassertion.

Configuration
REQ-027 With IMEM_ARB_LOCK_EN defined, ld_lock=1 SHALL give the loader strict priority and hold fe_req_ready=0, including while ld_req_valid=0.
REQ-028 Releasing ld_lock SHALL clear fe_burst_cnt; a lock asserted while a fetch response is pending SHALL still deliver that response.
REQ-029 Without IMEM_ARB_LOCK_EN, the ld_lock port and its logic SHALL be absent and arbitration is per REQ-018.

Structure
REQ-030 The state enum (IDLE, RSP_FE, RSP_LD) and the request/response packed structs SHALL be defined in the shared riscv_structures package.
REQ-031 Arbitration decision (grant, burst counter) SHALL be a sub-module imem_arb_pick; the FSM, flush tracking and muxing SHALL live in imem_arbiter.

Verification
REQ-032 Fetch-only reads at 0x0, 0x4, 0x8 on consecutive cycles -> fe_rsp_valid on three consecutive cycles with the memory words, and no bubble.
REQ-033 Both valid continuously with MAX_FE_BURST=4 -> grant pattern FE,FE,FE,FE,LD repeating; the loader is never starved for more than 4 cycles.
REQ-034 Loader write 0xDEADBEEF to 0x10, then fetch of 0x10 in the next cycle -> ld_rsp_valid with data 0, then fe_rsp_data=0xDEADBEEF.
REQ-035 Fetch granted at cycle N with fe_flush=1 at N+1 -> fe_rsp_valid stays 0; a new fetch granted at N+1 responds normally at N+2.
REQ-036 reset_n pulled low one cycle after a loader read grant -> ld_rsp_valid never asserts and all outputs are 0 during reset.
REQ-037 With IMEM_ARB_LOCK_EN: ld_lock=1 with fetch valid for 10 cycles -> fe_req_ready=0 throughout; lock release -> fetch granted next cycle.
